// File: rtl/rope_pkg.sv
// ---------------------------------------------------------------------------
// rope_pkg
// Shared definitions for the rope collision-side logic: screen geometry,
// datapath widths, the bounce controller state encoding and the boundary
// comparison helper used by rope_bounce_ctrl.
// ---------------------------------------------------------------------------
package rope_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int SCREEN_WIDTH           = 640;
    localparam int SCREEN_HEIGHT          = 480;

    // topLeftX is 11-bit signed. Boundary maths is done at 12 bits so that
    // topLeftX + OBJ_WIDTH - 1 cannot overflow.
    localparam int X_W    = 11;
    localparam int CALC_W = 12;

    // Hold-off counter width (HOLDOFF_FRAMES is limited to 0..15)
    localparam int HOLD_W = 4;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        FIRE  = 2'd1,
        HOLD  = 2'd2
    } bounce_state_t;

    // Sign-extend a screen X coordinate to the comparison width.
    function automatic logic signed [CALC_W-1:0] widen_x(
        input logic signed [X_W-1:0] x
    );
        return {x[X_W-1], x};
    endfunction

    // Boundary check in the current direction of travel only. A rope that
    // has just reversed away from a bound is never flagged again by it.
    function automatic logic boundary_hit(
        input logic signed [X_W-1:0]    x,
        input logic                     moving_right,
        input logic signed [CALC_W-1:0] left_bound,
        input logic signed [CALC_W-1:0] right_bound,
        input logic signed [CALC_W-1:0] width_m1
    );
        logic signed [CALC_W-1:0] left_edge;
        logic signed [CALC_W-1:0] right_edge;
        left_edge  = widen_x(x);
        right_edge = left_edge + width_m1;
        if (moving_right) begin
            return (right_edge >= right_bound);
        end
        return (left_edge <= left_bound);
    endfunction

endpackage : rope_pkg

// File: rtl/frame_holdoff_counter.sv
// ---------------------------------------------------------------------------
// frame_holdoff_counter
// Loadable 4-bit down-counter that counts frames (startOfFrame pulses), not
// clock cycles. Used to suppress collision checks for a number of frames
// after a direction toggle.
//
// Ports
//   clk          in   system clock
//   resetN       in   asynchronous active-low reset
//   load         in   load loadVal this cycle
//   loadVal      in   hold-off length in frames
//   startOfFrame in   one-cycle frame pulse; decrements the count
//   done         out  count has reached zero
// ---------------------------------------------------------------------------
module frame_holdoff_counter
    import rope_pkg::*;
(
    input  logic              clk,
    input  logic              resetN,
    input  logic              load,
    input  logic [HOLD_W-1:0] loadVal,
    input  logic              startOfFrame,
    output logic              done
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            // A frame pulse coinciding with the load is already the first
            // hold-off frame, so it is consumed straight away.
            if (startOfFrame && (loadVal != '0)) begin
                cnt_d = loadVal - HOLD_W'(1);
            end else begin
                cnt_d = loadVal;
            end
        end else if (startOfFrame && (cnt_q != '0)) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule : frame_holdoff_counter

// File: rtl/rope_bounce_ctrl.sv
// ---------------------------------------------------------------------------
// rope_bounce_ctrl
// Produces the dirToggle pulse consumed by the rope mover. On each frame
// start it evaluates a screen-boundary check on topLeftX and a latched
// rope/wall pixel-overlap flag; either one issues a single toggle, after
// which checks are suppressed for HOLDOFF_FRAMES frames.
//
// Ports
//   clk          in   system clock
//   resetN       in   asynchronous active-low reset
//   startOfFrame in   one-cycle pulse per frame (evaluation point)
//   topLeftX     in   signed 11-bit rope X from the mover
//   ropeDR       in   rope draw request for the current pixel
//   wallDR       in   wall draw request for the current pixel
//   dirToggle    out  registered one-cycle toggle pulse to the mover
//   movingRight  out  tracked direction of travel
//   bounceCount  out  number of toggles issued, wraps 255 -> 0
// ---------------------------------------------------------------------------
module rope_bounce_ctrl
    import rope_pkg::*;
#(
    parameter int LEFT_BOUND     = 0,
    parameter int RIGHT_BOUND    = SCREEN_WIDTH - 1,
    parameter int OBJ_WIDTH      = 32,
    parameter int HOLDOFF_FRAMES = 4,
    parameter bit INIT_RIGHT     = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic signed [X_W-1:0] topLeftX,
    input  logic                  ropeDR,
    input  logic                  wallDR,
    output logic                  dirToggle,
    output logic                  movingRight,
    output logic [COUNT_W-1:0]    bounceCount
);

    localparam logic signed [CALC_W-1:0] LEFT_B   = CALC_W'(LEFT_BOUND);
    localparam logic signed [CALC_W-1:0] RIGHT_B  = CALC_W'(RIGHT_BOUND);
    localparam logic signed [CALC_W-1:0] WIDTH_M1 = CALC_W'(OBJ_WIDTH - 1);
    localparam logic [HOLD_W-1:0]        HOLD_LEN = HOLD_W'(HOLDOFF_FRAMES);
    localparam bit                       HAS_HOLD = (HOLDOFF_FRAMES > 0);

    bounce_state_t         state_q,        state_d;
    logic signed [X_W-1:0] prev_x_q,       prev_x_d;
    logic                  hit_pending_q,  hit_pending_d;
    logic                  moving_right_q, moving_right_d;
    logic [COUNT_W-1:0]    bounce_count_q, bounce_count_d;
    logic                  dir_toggle_q,   dir_toggle_d;

    logic overlap;
    logic tracked_right;
    logic bound_hit;
    logic fire_now;
    logic can_fire;
    logic hold_load;
    logic hold_done;

    assign overlap = ropeDR & wallDR;

    // Direction implied by this frame's motion; unchanged when stationary.
    always_comb begin
        tracked_right = moving_right_q;
        if (topLeftX > prev_x_q) begin
            tracked_right = 1'b1;
        end else if (topLeftX < prev_x_q) begin
            tracked_right = 1'b0;
        end
    end

    assign bound_hit = boundary_hit(topLeftX, tracked_right, LEFT_B, RIGHT_B, WIDTH_M1);

    // An overlap in the same cycle as the frame pulse still counts.
    assign fire_now = startOfFrame & (bound_hit | hit_pending_q | overlap);

    // HOLD with an expired counter behaves as ARMED; this covers the single
    // cycle between the counter reaching zero and the state moving on.
    assign can_fire = (state_q == ARMED) || ((state_q == HOLD) && hold_done);

    always_comb begin
        state_d        = state_q;
        prev_x_d       = prev_x_q;
        moving_right_d = moving_right_q;
        bounce_count_d = bounce_count_q;
        dir_toggle_d   = 1'b0;
        hold_load      = 1'b0;

        // Overlap is latched in every state and discarded at each frame edge
        // once that frame's evaluation has used it.
        hit_pending_d = startOfFrame ? 1'b0 : (hit_pending_q | overlap);

        if (startOfFrame) begin
            prev_x_d       = topLeftX;
            moving_right_d = tracked_right;
        end

        case (state_q)
            ARMED, HOLD: begin
                if (can_fire) begin
                    if (fire_now) begin
                        state_d        = FIRE;
                        dir_toggle_d   = 1'b1;
                        // The bounce reversal wins over this frame's tracking.
                        moving_right_d = ~tracked_right;
                        bounce_count_d = bounce_count_q + COUNT_W'(1);
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            FIRE: begin
                hold_load = 1'b1;
                state_d   = HAS_HOLD ? HOLD : ARMED;
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    frame_holdoff_counter u_holdoff (
        .clk          (clk),
        .resetN       (resetN),
        .load         (hold_load),
        .loadVal      (HOLD_LEN),
        .startOfFrame (startOfFrame),
        .done         (hold_done)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= ARMED;
            prev_x_q       <= '0;
            hit_pending_q  <= 1'b0;
            moving_right_q <= INIT_RIGHT;
            bounce_count_q <= '0;
            dir_toggle_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_x_q       <= prev_x_d;
            hit_pending_q  <= hit_pending_d;
            moving_right_q <= moving_right_d;
            bounce_count_q <= bounce_count_d;
            dir_toggle_q   <= dir_toggle_d;
        end
    end

    assign dirToggle   = dir_toggle_q;
    assign movingRight = moving_right_q;
    assign bounceCount = bounce_count_q;

endmodule : rope_bounce_ctrl

// File: tb/tb_rope_bounce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rope_bounce_ctrl
// Scoreboard bench for rope_bounce_ctrl. Each frame pulse runs a reference
// model and queues the expected post-edge outputs; they are popped and
// compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_rope_bounce_ctrl;

    localparam int H      = 4;
    localparam int LEFT_B = 0;
    localparam int RIGHT_B = 639;
    localparam int OBJ_W  = 32;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic signed [10:0] topLeftX = '0;
    logic               ropeDR = 1'b0;
    logic               wallDR = 1'b0;
    logic               dirToggle;
    logic               movingRight;
    logic [7:0]         bounceCount;

    rope_bounce_ctrl #(
        .LEFT_BOUND     (LEFT_B),
        .RIGHT_BOUND    (RIGHT_B),
        .OBJ_WIDTH      (OBJ_W),
        .HOLDOFF_FRAMES (H),
        .INIT_RIGHT     (1'b1)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .topLeftX     (topLeftX),
        .ropeDR       (ropeDR),
        .wallDR       (wallDR),
        .dirToggle    (dirToggle),
        .movingRight  (movingRight),
        .bounceCount  (bounceCount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit tog;
        bit mr;
        int cnt;
    } exp_t;

    exp_t sb[$];

    int m_prev;
    bit m_mr;
    int m_cnt;
    bit m_armed;
    int m_hold;
    bit m_pending;

    task automatic model_reset();
        m_prev    = 0;
        m_mr      = 1'b1;
        m_cnt     = 0;
        m_armed   = 1'b1;
        m_hold    = 0;
        m_pending = 1'b0;
    endtask

    task automatic model_sof(input int x);
        bit   tr;
        bit   hit;
        exp_t e;
        tr     = (x > m_prev) ? 1'b1 : (x < m_prev) ? 1'b0 : m_mr;
        m_prev = x;
        e.tog  = 1'b0;
        if (m_armed) begin
            hit = tr ? (x + OBJ_W - 1 >= RIGHT_B) : (x <= LEFT_B);
            if (hit || m_pending) begin
                e.tog   = 1'b1;
                m_mr    = !tr;
                m_cnt   = (m_cnt + 1) % 256;
                m_hold  = H;
                m_armed = (H == 0);
            end else begin
                m_mr = tr;
            end
        end else begin
            m_mr = tr;
            m_hold--;
            if (m_hold == 0) m_armed = 1'b1;
        end
        m_pending = 1'b0;
        e.mr  = m_mr;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // One frame: idle cycles (overlap on [ov_lo, ov_lo+ov_n)), the frame
    // pulse, then one trailing cycle. Called and returns on a falling edge.
    task automatic do_frame(input int x, input int idle, input int ov_lo,
                            input int ov_n, input bit ov_sof, input bit solo);
        exp_t e;
        bit   ov;
        for (int i = 0; i < idle; i++) begin
            topLeftX = 11'(x);
            ov = (i >= ov_lo) && (i < ov_lo + ov_n);
            if (ov) begin
                ropeDR = 1'b1;
                wallDR = 1'b1;
                m_pending = 1'b1;
            end else if (solo) begin
                ropeDR = i[0];
                wallDR = !i[0];
            end else begin
                ropeDR = 1'b0;
                wallDR = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        topLeftX     = 11'(x);
        ropeDR       = ov_sof;
        wallDR       = ov_sof;
        startOfFrame = 1'b1;
        if (ov_sof) m_pending = 1'b1;
        model_sof(x);
        @(posedge clk);
        @(negedge clk);
        startOfFrame = 1'b0;
        ropeDR       = 1'b0;
        wallDR       = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("toggle", 32'(dirToggle), 32'(e.tog));
            check("moving_right", 32'(movingRight), 32'(e.mr));
            check("bounce_count", 32'(bounceCount), 32'(e.cnt));
        end
        @(posedge clk);
        @(negedge clk);
        check("pulse_width", 32'(dirToggle), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_toggle"}, 32'(dirToggle), 32'd0);
        check({tag, "_mr"},     32'(movingRight), 32'd1);
        check({tag, "_cnt"},    32'(bounceCount), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   base;
        int   guard;

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        resetN = 1'b1;
        @(negedge clk);

        // Right boundary: 600 is clear, 608 reaches 639.
        do_frame(600, 3, 0, 0, 1'b0, 1'b0);
        do_frame(608, 3, 0, 0, 1'b0, 1'b0);
        check("right_bound_cnt", 32'(bounceCount), 32'd1);
        check("right_bound_dir", 32'(movingRight), 32'd0);

        // Sitting at the bound after reversal: no re-toggle.
        for (int f = 0; f < 6; f++) do_frame(608, 3, 0, 0, 1'b0, 1'b0);
        check("stay_at_bound_cnt", 32'(bounceCount), 32'd1);

        // Three overlapping pixels mid-frame -> exactly one toggle.
        do_frame(300, 6, 2, 3, 1'b0, 1'b0);
        check("overlap_cnt", 32'(bounceCount), 32'd2);

        // Non-coincident rope/wall requests must not latch an overlap.
        for (int f = 0; f < 6; f++) do_frame(300, 4, 0, 0, 1'b0, 1'b1);
        check("solo_cnt", 32'(bounceCount), 32'd2);

        // Overlap every frame for 11 frame pulses -> toggles at 1, 6, 11.
        base = m_cnt;
        for (int f = 0; f < 11; f++) do_frame(300, 3, 1, 1, 1'b0, 1'b0);
        check("holdoff_cnt", 32'(bounceCount), 32'((base + 3) % 256));

        // Clear hold, then overlap only in the frame-pulse cycle.
        for (int f = 0; f < 5; f++) do_frame(300, 2, 0, 0, 1'b0, 1'b0);
        base = m_cnt;
        do_frame(300, 2, 0, 0, 1'b1, 1'b0);
        check("same_cycle_cnt", 32'(bounceCount), 32'((base + 1) % 256));

        // Left boundary while moving left, then parked at the bound.
        for (int f = 0; f < 5; f++) do_frame(300, 2, 0, 0, 1'b0, 1'b0);
        do_frame(10, 2, 0, 0, 1'b0, 1'b0);
        do_frame(0, 2, 0, 0, 1'b0, 1'b0);
        check("left_bound_dir", 32'(movingRight), 32'd1);
        base = m_cnt;
        for (int f = 0; f < 5; f++) do_frame(0, 2, 0, 0, 1'b0, 1'b0);
        check("left_stay_cnt", 32'(bounceCount), 32'(base));

        // Drive the counter to 255, then one more toggle wraps it to 0.
        guard = 0;
        while (m_cnt != 255 && guard < 2000) begin
            do_frame(300, 1, 0, 1, 1'b0, 1'b0);
            guard++;
        end
        check("reach_255", 32'(bounceCount), 32'd255);
        guard = 0;
        while (m_cnt == 255 && guard < 10) begin
            do_frame(300, 1, 0, 1, 1'b0, 1'b0);
            guard++;
        end
        check("wrap", 32'(bounceCount), 32'd0);

        // Reset in HOLD with two hold frames left.
        for (int f = 0; f < 5; f++) do_frame(300, 2, 0, 0, 1'b0, 1'b0);
        do_frame(300, 2, 0, 1, 1'b0, 1'b0);
        check("pre_rst_tog", 32'(m_armed), 32'd0);
        do_frame(300, 2, 0, 0, 1'b0, 1'b0);
        do_frame(300, 2, 0, 0, 1'b0, 1'b0);
        #2 resetN = 1'b0;
        #1 check_reset_outputs("hold_rst");
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        do_frame(300, 2, 0, 1, 1'b0, 1'b0);
        check("post_rst_cnt", 32'(bounceCount), 32'd1);

        // Reset asserted while dirToggle is high drops it immediately.
        for (int f = 0; f < 5; f++) do_frame(300, 2, 0, 0, 1'b0, 1'b0);
        ropeDR = 1'b1;
        wallDR = 1'b1;
        startOfFrame = 1'b1;
        m_pending = 1'b1;
        model_sof(300);
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        ropeDR = 1'b0;
        wallDR = 1'b0;
        e = sb.pop_front();
        check("async_pre_tog", 32'(dirToggle), 32'(e.tog));
        resetN = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rope_bounce_ctrl
